// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-port synchronous-read memory with a req/gnt/rvalid handshake.
// Build option ARB_RR_EN: round-robin arbitration replaces data priority plus the fetch starvation guard.
module mem_arbiter #(
  parameter int MEM_WORDS = 32768,
  parameter int MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_en,
  output logic [14:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  // Handshake: a port holds req until it sees gnt in the same cycle; the matching
  // rvalid (with rdata/err) follows exactly one cycle after that gnt.
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  logic        grant_i, grant_d, any_gnt;
  logic [31:0] sel_addr;
  logic        sel_write, in_range;

  // Response tag: NONE when tag_valid is 0; tag_port 1 means data port.
  logic tag_valid, tag_port, tag_write, tag_err;

`ifdef ARB_RR_EN
  logic last_gnt;
`else
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
  logic [3:0] wait_cnt;
`endif

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (reset_n) begin
      if (i_req && d_req) begin
`ifdef ARB_RR_EN
        if (last_gnt) grant_i = 1'b1;
        else          grant_d = 1'b1;
`else
        if (wait_cnt == MAX_W) grant_i = 1'b1;
        else                   grant_d = 1'b1;
`endif
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  assign any_gnt   = grant_i | grant_d;
  assign sel_addr  = grant_d ? d_addr : i_addr;
  assign sel_write = grant_d && (d_wstrb != 4'd0);
  assign in_range  = {1'b0, sel_addr} < ADDR_LIMIT;

  assign i_gnt   = grant_i;
  assign d_gnt   = grant_d;
  assign m_en    = any_gnt && in_range;
  assign m_addr  = m_en ? sel_addr[16:2] : 15'd0;
  assign m_wstrb = (m_en && grant_d) ? d_wstrb : 4'd0;
  assign m_wdata = (m_en && grant_d) ? d_wdata : 32'd0;

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     last_gnt <= 1'b1;
    else if (any_gnt) last_gnt <= grant_d;
  end
`else
  // Counts cycles a fetch has been refused; saturates so the force-grant condition holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 wait_cnt <= 4'd0;
    else if (i_req && !grant_i)   wait_cnt <= (wait_cnt == MAX_W) ? wait_cnt : wait_cnt + 4'd1;
    else                          wait_cnt <= 4'd0;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= 1'b0;
      tag_port  <= 1'b0;
      tag_write <= 1'b0;
      tag_err   <= 1'b0;
    end else begin
      tag_valid <= any_gnt;
      tag_port  <= grant_d;
      tag_write <= sel_write;
      tag_err   <= any_gnt && !in_range;
    end
  end

  logic        rd_ok;
  assign rd_ok = tag_valid && !tag_write && !tag_err;

  assign i_rvalid = tag_valid && !tag_port;
  assign d_rvalid = tag_valid &&  tag_port;
  assign i_err    = i_rvalid && tag_err;
  assign d_err    = d_rvalid && tag_err;
  assign i_rdata  = (i_rvalid && rd_ok) ? m_rdata : 32'd0;
  assign d_rdata  = (d_rvalid && rd_ok) ? m_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural memory on m_*, reference memory model,
// and an expected-response queue checked one cycle after each grant.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_en;
  logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
  logic [14:0] m_addr;
  logic [3:0]  m_wstrb;

  mem_arbiter #(.MEM_WORDS(32768), .MAX_WAIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Clock/reset
  always #5 clk = ~clk;

  // Behavioural synchronous-read, byte-write memory
  logic [31:0] mem [0:32767];
  logic [31:0] ref_mem [0:32767];
  initial m_rdata = '0;
  always @(posedge clk) begin
    if (m_en) begin
      if (m_wstrb == 4'd0) m_rdata <= mem[m_addr];
      else begin
        for (int b = 0; b < 4; b++)
          if (m_wstrb[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      end
    end
  end

  // Scoreboard: {i_rvalid, d_rvalid, err, rdata}
  logic [34:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic step(input string tag, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [31:0] da, input logic [3:0] ws,
                      input logic [31:0] wd, input logic eg_i, input logic eg_d);
    logic [31:0] a, data;
    logic        inr, wr, exp_men;
    logic [34:0] exp_rsp;
    i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_wstrb = ws; d_wdata = wd;
    @(negedge clk);
    exp_rsp = (exp_q.size() > 0) ? exp_q.pop_front() : 35'd0;
    check({tag, "/rsp"}, 64'({i_rvalid, d_rvalid, i_err | d_err, i_rdata | d_rdata}), 64'(exp_rsp));
    check({tag, "/gnt"}, 64'({i_gnt, d_gnt}), 64'({eg_i, eg_d}));
    a       = eg_d ? da : ia;
    inr     = a < 32'h0002_0000;
    wr      = eg_d && (ws != 4'd0);
    exp_men = (eg_i | eg_d) && inr;
    check({tag, "/men"}, 64'({m_en, m_addr, m_wstrb}),
          64'({exp_men, exp_men ? a[16:2] : 15'd0, (exp_men && eg_d) ? ws : 4'd0}));
    if (eg_i | eg_d) begin
      data = (!inr || wr) ? 32'd0 : ref_mem[a[16:2]];
      if (inr && wr)
        for (int b = 0; b < 4; b++)
          if (ws[b]) ref_mem[a[16:2]][8*b +: 8] = wd[8*b +: 8];
      exp_q.push_back({eg_i, eg_d, !inr, data});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] rnd;
    logic        exp_i;
    for (int w = 0; w < 32768; w++) begin
      mem[w]     = (32'(w) * 32'h0101_0101) ^ 32'hA5A5_5A5A;
      ref_mem[w] = mem[w];
    end
    mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;

    // Reset state with both ports requesting
    i_req = 1'b1; d_req = 1'b1;
    #12;
    check("reset/gnt_men", 64'({i_gnt, d_gnt, m_en}), 64'd0);
    check("reset/rsp", 64'({i_rvalid, d_rvalid, i_err, d_err}), 64'd0);
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle("idle0");

    // Fetch only
    step("fetch10", 1'b1, 32'h10, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0);
    idle("fetch10_rsp");

    // Byte write then back-to-back read of the same word
    step("bwr", 1'b0, 32'd0, 1'b1, 32'h4, 4'b0010, 32'h0000_AB00, 1'b0, 1'b1);
    step("brd", 1'b0, 32'd0, 1'b1, 32'h4, 4'b0000, 32'd0, 1'b0, 1'b1);
    idle("brd_rsp");

    // Out of range read and write
    step("oor_rd", 1'b0, 32'd0, 1'b1, 32'h0002_0000, 4'd0, 32'd0, 1'b0, 1'b1);
    step("oor_wr", 1'b0, 32'd0, 1'b1, 32'h0002_0004, 4'hF, 32'h1234_5678, 1'b0, 1'b1);
    step("oor_fetch", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0);
    idle("oor_rsp");

    // Back-to-back fetches
    step("b2b0", 1'b1, 32'h0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0);
    step("b2b4", 1'b1, 32'h4, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0);
    step("b2b8", 1'b1, 32'h8, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0);
    idle("b2b_rsp");

    // Random full-word write and read back at the top word
    rnd = 32'($urandom_range(0, 32'h7FFF_FFFF)) ^ 32'h8000_0001;
    step("rwr", 1'b0, 32'd0, 1'b1, 32'h0001_FFFC, 4'hF, rnd, 1'b0, 1'b1);
    step("rrd", 1'b0, 32'd0, 1'b1, 32'h0001_FFFC, 4'h0, 32'd0, 1'b0, 1'b1);

    // Contention: data granted last, fetch counter cleared
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_RR_EN
      exp_i = (k % 2) == 0;
`else
      exp_i = (k % 5) == 4;
`endif
      step("contend", 1'b1, 32'hC, 1'b1, 32'h8, 4'd0, 32'd0, exp_i, !exp_i);
    end
    idle("contend_rsp");

    // Reset pulled before the edge that would capture a granted fetch
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    check("rst_mid/gnt", 64'(i_gnt), 64'd1);
    #1 reset_n = 1'b0;
    #1 check("rst_mid/gnt_low", 64'({i_gnt, m_en}), 64'd0);
    @(posedge clk); #1;
    check("rst_mid/rsp", 64'({i_rvalid, d_rvalid}), 64'd0);
    i_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle("rst_after0");
    idle("rst_after1");

    // Memory unchanged by the aborted access
    step("post_rst", 1'b1, 32'h10, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0);
    step("post_rst_d", 1'b0, 32'd0, 1'b1, 32'h4, 4'd0, 32'd0, 1'b0, 1'b1);
    idle("post_rst_rsp");
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
